urv_trap_unit: RTL

Machine-mode trap and interrupt controller for the uRV execute stage. It owns the architectural trap CSRs: mstatus, mie, mip, mepc and mcause. It feeds their current values to the CSR read/modify unit and takes back that unit's computed write value on CSR commits. It also decides trap entry and mret, and gives the fetch stage the redirect target.

---
 rtl/urv_trap_unit.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/urv_trap_unit.sv
// urv_trap_unit: machine-mode trap CSRs (mstatus, mie, mip, mepc, mcause),
// trap entry / mret decision and fetch redirect for the uRV execute stage.
module urv_trap_unit #(
  parameter logic [31:0] TRAP_VECTOR = 32'h00000008
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        x_valid_i,
  input  logic        x_stall_i,
  input  logic        x_kill_i,
  input  logic [31:0] x_pc_i,
  input  logic        x_is_csr_i,
  input  logic [11:0] x_csr_sel_i,
  input  logic [31:0] x_csr_write_value_i,
  input  logic        x_exception_i,
  input  logic [3:0]  x_exception_cause_i,
  input  logic        x_is_mret_i,
  input  logic        irq_ext_i,
  input  logic        timer_tick_i,
  output logic [31:0] csr_mstatus_o,
  output logic [31:0] csr_mip_o,
  output logic [31:0] csr_mie_o,
  output logic [31:0] csr_mepc_o,
  output logic [31:0] csr_mcause_o,
  output logic        x_redirect_o,
  output logic [31:0] x_redirect_pc_o
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MIP     = 12'h344;

  logic        r_irq_meta;
  logic        r_meip;
  logic        r_mtip;
  logic        r_mie_meie;
  logic        r_mie_mtie;
  logic        r_mstatus_mie;
  logic        r_mstatus_mpie;
  logic [31:0] r_mepc;
  logic        r_mcause_irq;
  logic [3:0]  r_mcause_code;

  logic        w_commit;
  logic [31:0] w_mip;
  logic [31:0] w_mie;
  logic [31:0] w_pending;
  logic        w_irq_req;
  logic [3:0]  w_irq_code;
  logic        w_take_exc;
  logic        w_take_irq;
  logic        w_take_mret;
  logic        w_csr_wr;
  logic        w_trap;

  assign w_commit   = x_valid_i & ~x_stall_i & ~x_kill_i;
  assign w_mip      = {20'b0, r_meip, 3'b0, r_mtip, 7'b0};
  assign w_mie      = {20'b0, r_mie_meie, 3'b0, r_mie_mtie, 7'b0};
  assign w_pending  = w_mip & w_mie;
  assign w_irq_req  = r_mstatus_mie & (|w_pending);
  assign w_irq_code = w_pending[11] ? 4'd11 : 4'd7;

  // Exactly one event acts per commit: exception > interrupt > mret > CSR write.
  assign w_take_exc  = w_commit & x_exception_i;
  assign w_take_irq  = w_commit & ~x_exception_i & w_irq_req;
  assign w_take_mret = w_commit & ~x_exception_i & ~w_irq_req & x_is_mret_i;
  assign w_csr_wr    = w_commit & ~x_exception_i & ~w_irq_req & ~x_is_mret_i & x_is_csr_i;
  assign w_trap      = w_take_exc | w_take_irq;

  // Gating with rst_i drops the redirect as soon as reset asserts.
  assign x_redirect_o    = rst_i & (w_trap | w_take_mret);
  assign x_redirect_pc_o = !x_redirect_o ? '0 : (w_take_mret ? r_mepc : TRAP_VECTOR);

  assign csr_mstatus_o = {19'b0, 2'b11, 3'b0, r_mstatus_mpie, 3'b0, r_mstatus_mie, 3'b0};
  assign csr_mip_o     = w_mip;
  assign csr_mie_o     = w_mie;
  assign csr_mepc_o    = r_mepc;
  assign csr_mcause_o  = {r_mcause_irq, 27'b0, r_mcause_code};

  // Two-flop synchroniser for the external interrupt level (MEIP).
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_irq_meta <= 1'b0;
      r_meip     <= 1'b0;
    end else begin
      r_irq_meta <= irq_ext_i;
      r_meip     <= r_irq_meta;
    end
  end

  // Sticky MTIP: a tick sets it regardless of commit and beats a clearing write.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mtip <= 1'b0;
    end else if (timer_tick_i) begin
      r_mtip <= 1'b1;
    end else if (w_csr_wr && x_csr_sel_i == CSR_MIP && !x_csr_write_value_i[7]) begin
      r_mtip <= 1'b0;
    end
  end

  // Trap entry, mret and CSR write updates of the architectural trap state.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mie_meie     <= 1'b0;
      r_mie_mtie     <= 1'b0;
      r_mstatus_mie  <= 1'b0;
      r_mstatus_mpie <= 1'b0;
      r_mepc         <= '0;
      r_mcause_irq   <= 1'b0;
      r_mcause_code  <= '0;
    end else if (w_trap) begin
      r_mepc         <= x_pc_i & 32'hFFFF_FFFC;
      r_mcause_irq   <= w_take_irq;
      r_mcause_code  <= w_take_exc ? x_exception_cause_i : w_irq_code;
      r_mstatus_mpie <= r_mstatus_mie;
      r_mstatus_mie  <= 1'b0;
    end else if (w_take_mret) begin
      r_mstatus_mie  <= r_mstatus_mpie;
      r_mstatus_mpie <= 1'b1;
    end else if (w_csr_wr) begin
      case (x_csr_sel_i)
        CSR_MSTATUS: begin
          r_mstatus_mie  <= x_csr_write_value_i[3];
          r_mstatus_mpie <= x_csr_write_value_i[7];
        end
        CSR_MIE: begin
          r_mie_meie <= x_csr_write_value_i[11];
          r_mie_mtie <= x_csr_write_value_i[7];
        end
        CSR_MEPC:   r_mepc <= x_csr_write_value_i & 32'hFFFF_FFFC;
        CSR_MCAUSE: begin
          r_mcause_irq  <= x_csr_write_value_i[31];
          r_mcause_code <= x_csr_write_value_i[3:0];
        end
        default: ;
      endcase
    end
  end

endmodule
